// File: rtl/dp_axil_reg_slv.sv
// AXI4-Lite register slave: NUM_REGS x 32-bit R/W bank, exported flat with per-register write pulses.
// Latency: bvalid 1 cycle after the later of the AW/W handshakes; rvalid 1 cycle after the AR handshake.
// Backpressure: one write and one read in flight; bready/rready low stalls that channel indefinitely.
module dp_axil_reg_slv #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          NUM_REGS   = 16,
    parameter logic [31:0] RESET_VAL  = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [ADDR_WIDTH-1:0]    awaddr,
    input  logic                     wvalid,
    output logic                     wready,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [1:0]               bresp,
    input  logic                     arvalid,
    output logic                     arready,
    input  logic [ADDR_WIDTH-1:0]    araddr,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [31:0]              rdata,
    output logic [1:0]               rresp,
    output logic [32*NUM_REGS-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      reg_wr_o
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int RI_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_HAVE_AW = 2'd1;
    localparam logic [1:0] W_HAVE_W  = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;
    localparam logic       R_IDLE    = 1'b0;
    localparam logic       R_DATA    = 1'b1;

    logic [31:0]           regs [NUM_REGS];
    logic [1:0]            w_state, w_nxt;
    logic                  r_state, r_nxt;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs, do_wr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [RI_W-1:0]       wr_ri, rd_ri;
    logic                  wr_ok, rd_ok;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;
    assign b_hs  = bvalid && bready;
    assign r_hs  = rvalid && rready;

    // The commit cycle may take either half live from the bus or from the holding registers.
    assign wr_addr = aw_hs ? awaddr : aw_addr_q;
    assign wr_data = w_hs ? wdata : wdata_q;
    assign wr_strb = w_hs ? wstrb : wstrb_q;

    // Out-of-range indices never alias: the full index is compared, only then truncated.
    assign wr_idx = wr_addr[ADDR_WIDTH-1:2];
    assign rd_idx = araddr[ADDR_WIDTH-1:2];
    assign wr_ok  = (32'(wr_idx) < NUM_REGS);
    assign rd_ok  = (32'(rd_idx) < NUM_REGS);
    assign wr_ri  = wr_idx[RI_W-1:0];
    assign rd_ri  = rd_idx[RI_W-1:0];

    // Write FSM next state; do_wr marks the cycle that enters W_RESP.
    always_comb begin
        w_nxt = w_state;
        do_wr = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_nxt = W_RESP;
                    do_wr = 1'b1;
                end else if (aw_hs) begin
                    w_nxt = W_HAVE_AW;
                end else if (w_hs) begin
                    w_nxt = W_HAVE_W;
                end
            end
            W_HAVE_AW: if (w_hs) begin
                w_nxt = W_RESP;
                do_wr = 1'b1;
            end
            W_HAVE_W: if (aw_hs) begin
                w_nxt = W_RESP;
                do_wr = 1'b1;
            end
            W_RESP: if (b_hs) w_nxt = W_IDLE;
            default: w_nxt = W_IDLE;
        endcase
    end

    // Write FSM state, holding registers and registered handshake outputs (readies low in reset).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state   <= W_IDLE;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else begin
            w_state <= w_nxt;
            if (aw_hs) aw_addr_q <= awaddr;
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            awready <= (w_nxt == W_IDLE) || (w_nxt == W_HAVE_W);
            wready  <= (w_nxt == W_IDLE) || (w_nxt == W_HAVE_AW);
            bvalid  <= (w_nxt == W_RESP);
            if (do_wr) bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Register bank: byte-lane update in the commit cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else if (do_wr && wr_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_strb[k]) regs[wr_ri][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    // Write pulse aligned with the updated register value; fires even when wstrb is zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_wr_o <= '0;
        end else begin
            reg_wr_o <= '0;
            if (do_wr && wr_ok) reg_wr_o[wr_ri] <= 1'b1;
        end
    end

    // Read FSM next state.
    always_comb begin
        r_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_nxt = R_DATA;
            R_DATA:  if (r_hs) r_nxt = R_IDLE;
            default: r_nxt = R_IDLE;
        endcase
    end

    // Read path: captures the pre-write register value if a write commits on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            r_state <= r_nxt;
            arready <= (r_nxt == R_IDLE);
            rvalid  <= (r_nxt == R_DATA);
            if (ar_hs) begin
                rdata <= rd_ok ? regs[rd_ri] : 32'h0;
                rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_o[32*g +: 32] = regs[g];
        end
    endgenerate

endmodule

// File: tb/tb_dp_axil_reg_slv.sv
// Testbench for dp_axil_reg_slv: scoreboarded B/R responses plus direct checks on handshakes and pulses.
// Latency: checks bvalid/rvalid one cycle after the completing handshake.
// Backpressure: exercises a bready stall and a reset landing in the write-response state.
module tb_dp_axil_reg_slv;
    localparam int NREG = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic              bready = 1'b1, rready = 1'b1;
    logic [11:0]       awaddr = '0, araddr = '0;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              awready, wready, bvalid, arready, rvalid;
    logic [1:0]        bresp, rresp;
    logic [31:0]       rdata;
    logic [32*NREG-1:0] regs_o;
    logic [NREG-1:0]   reg_wr_o;

    logic [31:0]       mdl [NREG];
    logic [1:0]        bq [$];
    logic [33:0]       rq [$];
    int                n_chk = 0;
    int                n_err = 0;

    dp_axil_reg_slv #(.ADDR_WIDTH(12), .NUM_REGS(NREG), .RESET_VAL(32'h0)) dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .regs_o(regs_o), .reg_wr_o(reg_wr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0=awready 1=wready 2=arready
    task automatic wait_rdy(input int which);
        logic r;
        for (int n = 0; n < 50; n++) begin
            r = (which == 0) ? awready : (which == 1) ? wready : arready;
            if (r) return;
            tick();
        end
        r = (which == 0) ? awready : (which == 1) ? wready : arready;
        chk("rdy_timeout", r, 1);
    endtask

    // Response monitor, sampled mid-cycle; a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!reset && bvalid && bready) begin
            if (bq.size() == 0) chk("b_unexpected", bvalid, 0);
            else chk("bresp", bresp, bq.pop_front());
        end
        if (!reset && rvalid && rready) begin
            if (rq.size() == 0) chk("r_unexpected", rvalid, 0);
            else chk("rresp_rdata", {rresp, rdata}, rq.pop_front());
        end
    end

    // mode 0: AW+W together, 1: W first then AW 3 cycles later, 2: AW first then W
    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input int mode);
        int idx;
        bit ok;
        logic [NREG-1:0] pulse;
        idx   = int'(a[11:2]);
        ok    = (idx < NREG);
        pulse = ok ? (NREG'(1) << idx) : '0;
        bq.push_back(ok ? 2'b00 : 2'b10);
        if (mode != 2) begin wvalid = 1'b1; wdata = d; wstrb = s; end
        if (mode != 1) begin awvalid = 1'b1; awaddr = a; end
        if (mode == 0) begin
            wait_rdy(0);
            tick();
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end else if (mode == 1) begin
            wait_rdy(1);
            tick();
            wvalid = 1'b0;
            chk("hw_awready", awready, 1);
            chk("hw_wready", wready, 0);
            repeat (3) @(posedge clk);
            #1;
            chk("hw_wait_wready", wready, 0);
            awvalid = 1'b1; awaddr = a;
            wait_rdy(0);
            tick();
            awvalid = 1'b0;
        end else begin
            wait_rdy(0);
            tick();
            awvalid = 1'b0;
            chk("ha_awready", awready, 0);
            chk("ha_wready", wready, 1);
            repeat (3) @(posedge clk);
            #1;
            wvalid = 1'b1; wdata = d; wstrb = s;
            wait_rdy(1);
            tick();
            wvalid = 1'b0;
        end
        chk("b_latency", bvalid, 1);
        chk("wr_pulse", reg_wr_o, pulse);
        if (ok) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
            chk("regs_o", regs_o[32*idx +: 32], mdl[idx]);
        end
        if (bready) begin
            tick();
            chk("wr_pulse_off", reg_wr_o, 0);
            chk("b_done", bvalid, 0);
        end
    endtask

    task automatic do_read(input logic [11:0] a);
        int idx;
        idx = int'(a[11:2]);
        if (idx < NREG) rq.push_back({2'b00, mdl[idx]});
        else rq.push_back({2'b10, 32'h0});
        arvalid = 1'b1; araddr = a;
        wait_rdy(2);
        tick();
        arvalid = 1'b0;
        chk("r_latency", rvalid, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NREG; i++) mdl[i] = 32'h0;
        #12;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_regs", |regs_o, 0);
        chk("rst_wr", reg_wr_o, 0);
        #1 reset = 1'b0;
        tick();
        chk("idle_awready", awready, 1);
        chk("idle_arready", arready, 1);

        do_read(12'h004);
        do_write(12'h008, 32'hDEADBEEF, 4'hF, 0);
        do_read(12'h008);
        do_write(12'h00C, 32'h12345678, 4'hF, 1);
        do_read(12'h00C);
        do_write(12'h00C, 32'h87654321, 4'hF, 2);
        do_read(12'h00C);
        do_write(12'h004, 32'hFFFFFFFF, 4'hF, 0);
        do_write(12'h004, 32'h00AA00BB, 4'b0101, 0);
        chk("partial_reg1", regs_o[63:32], 32'hFFAAFFBB);
        do_read(12'h004);
        do_write(12'h040, 32'h55555555, 4'hF, 0);
        do_read(12'hFFC);
        do_write(12'h01C, 32'hFFFFFFFF, 4'h0, 0);
        do_read(12'h01C);

        // Read and write of the same register on the same edge: read sees the old value.
        fork
            do_read(12'h008);
            do_write(12'h008, 32'h11112222, 4'hF, 0);
        join
        do_read(12'h008);

        bready = 1'b0;
        do_write(12'h014, 32'hCAFEF00D, 4'hF, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_bvalid", bvalid, 1);
            chk("bp_bresp", bresp, 2'b00);
            chk("bp_awready", awready, 0);
        end
        bready = 1'b1;
        tick();
        chk("bp_release", bvalid, 0);

        bready = 1'b0;
        do_write(12'h018, 32'h0BADCAFE, 4'hF, 0);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_bvalid", bvalid, 0);
        chk("rst_mid_regs", |regs_o, 0);
        bq.delete();
        for (int i = 0; i < NREG; i++) mdl[i] = 32'h0;
        bready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        do_read(12'h014);
        do_read(12'h008);

        tick();
        chk("bq_empty", bq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dp_axil_reg_slv.md
Name: dp_axil_reg_slv

Overview:
AXI4-Lite responder (slave) for the Data Plane control path. It terminates the AXI-Lite initiator traffic the DP bench drives and implements a bank of NUM_REGS 32-bit read/write registers. Register values are exported to the data plane as flat vectors, along with a per-register write strobe. It is the responding end of the same AXI-Lite interface that the DP DUT checker monitors.

Parameters:
ADDR_WIDTH, 12, AXI-Lite address width in bits
NUM_REGS, 16, number of 32-bit registers, word-aligned from offset 0x000
RESET_VAL, 0, reset value applied to every register (32-bit)

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  ADDR_WIDTH  write byte address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  32  write data
wstrb  in  4  byte-lane strobes
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  write response code
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  ADDR_WIDTH  read byte address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  32  read data
rresp  out  2  read response code
regs_o  out  32*NUM_REGS  register contents; register i is at bits [32i+31:32i]
reg_wr_o  out  NUM_REGS  one-cycle pulse when register i is written

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled externally) forces the following values:
  - awready=0, wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rdata=0, rresp=0, reg_wr_o=0.
  - All registers = RESET_VAL.
  - Both state machines go to IDLE.
- Reset mid-transaction aborts it with no response; the initiator must re-issue.
- Address decode:
  - index = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored.
  - index < NUM_REGS gives OKAY (2'b00). Otherwise SLVERR (2'b10); no register is modified and rdata=0.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: awready=1, wready=1.
    - AW and W handshakes in the same cycle -> W_RESP.
    - AW only -> latch awaddr, go to W_HAVE_AW (awready=0, wready=1).
    - W only -> latch wdata/wstrb, go to W_HAVE_W (awready=1, wready=0).
  - W_HAVE_AW, on W handshake -> W_RESP. W_HAVE_W, on AW handshake -> W_RESP.
  - Entering W_RESP: the register update happens that same cycle.
    - Only byte lanes with wstrb[k]=1 are updated.
    - reg_wr_o[index] pulses for 1 cycle on an OKAY write, including wstrb=0.
    - bvalid=1 and bresp is set on the next cycle.
  - W_RESP: awready=0, wready=0. Hold bvalid and bresp stable until bready; on bvalid&&bready -> W_IDLE.
  - Minimum write latency: 1 cycle from the last of AW/W handshake to bvalid. One write is outstanding at a time.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake, capture rdata/rresp from the current register value, set rvalid=1 on the next cycle, go to R_DATA.
  - R_DATA: arready=0. Hold rvalid, rdata and rresp stable until rready; on rvalid&&rready -> R_IDLE.
  - Read latency is 1 cycle. One read is outstanding at a time.
- Simultaneous read and write:
  - The two FSMs are independent.
  - If an AR handshake and a write register update to the same index occur in the same cycle, rdata returns the pre-write value.
- Wrap-around: none. Addresses beyond NUM_REGS*4 always return SLVERR and do not alias.
- Reaching W_IDLE and R_IDLE requires the response to have been accepted (bvalid&&bready, rvalid&&rready). bready or rready held low therefore stalls the corresponding channel indefinitely; that is legal.

Test Plan:
- Reset check: assert reset -> all ready/valid outputs 0 and regs_o all zero. Then read 0x004 -> rdata=0x00000000, rresp=OKAY, rvalid 1 cycle after the AR handshake.
- Write then read: AW and W together with addr 0x008, data 0xDEADBEEF, wstrb 4'hF:
  - bvalid next cycle, bresp=OKAY.
  - reg_wr_o[2] pulses once.
  - A subsequent read of 0x008 returns 0xDEADBEEF.
- Channel ordering:
  - W first (0x12345678 to 0x00C), AW 3 cycles later -> awready stays high and wready goes low while waiting; bvalid arrives 1 cycle after the AW handshake; reg 3 = 0x12345678.
  - Repeat with AW first -> same result.
- Partial strobe: reg 1 = 0xFFFFFFFF, then write 0x00AA00BB with wstrb 4'b0101 -> reg 1 = 0xFFAAFFBB.
- Out of range: write to 0x040 (index 16) -> bresp=SLVERR and no reg_wr_o pulse. Read of 0xFFC -> rresp=SLVERR, rdata=0.
- Back-pressure and reset:
  - Hold bready=0 for 10 cycles -> bvalid/bresp stay stable and awready=0.
  - Assert reset while in W_RESP -> bvalid drops immediately and registers return to RESET_VAL.
